tick_timer: RTL and testbench

//  Consumer end of the clock-divider outputs. Takes a slow, 50%-duty toggling

---
 rtl/tick_timer.sv | 110 +++++++++++
 tb/tb_tick_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Resynchronises a slow toggling divided clock into ticks and drives a loadable
// down-counting timer. Define AUTO_RELOAD_EN for periodic (auto-reload) mode.
module tick_timer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             tick_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic             tick_pulse,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       reload_q, reload_d;
    logic                   done_q, done_d;

    // tick_in is treated purely as data: synchronise, then edge-detect against history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q     <= sync_q[SYNC_STAGES-1];
            tick_pulse <= sync_q[SYNC_STAGES-1] ^ hist_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (start && (count_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick_pulse) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer; one-shot tests by default,
// periodic-mode test when AUTO_RELOAD_EN is defined.
module tb_tick_timer;

    localparam int unsigned WIDTH = 16;

    logic             rst;
    logic             clk;
    logic             tick_in;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             tick_pulse;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             expired;

    int checks = 0;
    int errors = 0;

    tick_timer #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .rst        (rst),
        .clk        (clk),
        .tick_in    (tick_in),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .tick_pulse (tick_pulse),
        .count      (count),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Toggle tick_in and wait until the resulting tick has been applied to count
    task automatic do_tick();
        tick_in = ~tick_in;
        repeat (4) step();
    endtask

    task automatic pulse_window(input string tag);
        int pulses;
        int first_at;
        pulses   = 0;
        first_at = -1;
        tick_in  = ~tick_in;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (tick_pulse) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_latency"}, first_at, 3);
    endtask

    initial begin
        rst = 1'b1; tick_in = 1'b0; load = 1'b0; load_value = '0;
        start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        rst = 1'b0;
        repeat (5) step();

        // Test 1: idle after reset
        check("idle_pulse", tick_pulse, 0);
        check("idle_count", count, 0);
        check("idle_running", running, 0);
        check("idle_done", done, 0);
        check("idle_expired", expired, 0);

        // Async reset mid-RUN
        do_load(16'd9);
        do_start();
        check("pre_rst_running", running, 1);
        rst = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_running", running, 0);
        check("midrst_done", done, 0);
        check("midrst_expired", expired, 0);
        check("midrst_pulse", tick_pulse, 0);
        step();
        rst = 1'b0;
        step();
        do_start();
        check("post_rst_start_ignored", running, 0);

        // Test 2: each tick_in edge gives one pulse, 3 clk later
        pulse_window("rise");
        pulse_window("fall");

`ifndef AUTO_RELOAD_EN
        // Test 3: one-shot countdown from 5
        do_load(16'd5);
        check("t3_load_count", count, 5);
        check("t3_load_running", running, 0);
        do_start();
        check("t3_running", running, 1);
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            check("t3_count", count, 5 - i);
            check("t3_done_early", done, 0);
        end
        do_tick();
        check("t3_count_zero", count, 0);
        check("t3_done", done, 1);
        check("t3_expired", expired, 1);
        check("t3_running_off", running, 0);
        step();
        check("t3_done_one_cycle", done, 0);
        do_tick();
        do_tick();
        do_start();
        check("t3_hold_count", count, 0);
        check("t3_hold_expired", expired, 1);
        check("t3_hold_running", running, 0);
        check("t3_hold_done", done, 0);

        // Test 4: stop/resume
        do_load(16'd3);
        check("t4_load_clears_expired", expired, 0);
        do_start();
        do_tick();
        check("t4_count_2", count, 2);
        do_stop();
        check("t4_paused", running, 0);
        repeat (4) do_tick();
        check("t4_paused_count", count, 2);
        do_start();
        check("t4_resumed", running, 1);
        do_tick();
        check("t4_count_1", count, 1);
        do_tick();
        check("t4_count_0", count, 0);
        check("t4_done", done, 1);
        check("t4_expired", expired, 1);

        // stop in the same cycle as tick_pulse: no decrement
        do_load(16'd3);
        do_start();
        tick_in = ~tick_in;
        repeat (3) step();
        check("t4_pulse_present", tick_pulse, 1);
        do_stop();
        check("t4_stop_tick_count", count, 3);
        check("t4_stop_tick_running", running, 0);
`else
        // Test 6: periodic mode
        do_load(16'd2);
        do_start();
        for (int i = 1; i <= 6; i++) begin
            do_tick();
            check("t6_count", count, (i % 2 == 1) ? 1 : 2);
            check("t6_done", done, (i % 2 == 0) ? 1 : 0);
            check("t6_running", running, 1);
            check("t6_expired", expired, 0);
        end
`endif

        // Test 5: load 0 then start is ignored; load wins over start
        do_load(16'd0);
        do_start();
        check("t5_zero_running", running, 0);
        check("t5_zero_count", count, 0);
        load_value = 16'd7;
        load = 1'b1;
        start = 1'b1;
        step();
        load = 1'b0;
        start = 1'b0;
        check("t5_load_wins_count", count, 7);
        check("t5_load_wins_running", running, 0);

        // Maximum load value is legal and decrements normally
        do_load(16'hFFFF);
        do_start();
        do_tick();
        check("max_count", count, 32'h0000FFFE);
        check("max_running", running, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
